// File: rtl/alu_seq.sv
// alu_seq: multi-cycle RV32 ALU sequencer around alu32; define ALU_SEQ_BARREL_EN for single-cycle barrel shifts
module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [6:0]  funct7,
  input  logic [1:0]  sel,
  output logic [31:0] y
);
  logic sub;
  assign sub = funct7 == 7'h20;
  always_comb y = sel == 2'd0 ? (sub ? a - b : a + b) : sel == 2'd1 ? a ^ b : sel == 2'd2 ? a | b : a & b;
endmodule

module alu_seq #(
  parameter int SHAMT_W = 5,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  sel,
  input  logic [6:0]  funct7,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state, op, alu_s;
  logic [31:0] acc, b_r, out_r, alu_a, alu_b, alu_y, shift_next;
  logic [6:0] alu_f;
  logic [CNT_W-1:0] cnt, shamt_ext;
  logic [SHAMT_W-1:0] shamt;
  logic sra_r, calc, cmp_bit;
  assign shamt = in2[SHAMT_W-1:0];
  assign shamt_ext = {{(CNT_W-SHAMT_W){1'b0}}, shamt};
  assign calc = state == CALC;
  // compares reuse the ALU as a subtractor on the latched operands
  always_comb begin
    alu_a = calc ? acc : in1;
    alu_b = calc ? b_r : in2;
    alu_f = calc ? 7'h20 : funct7;
    alu_s = calc ? 2'd0 : sel[1:0];
  end
  alu32 u_alu (.a(alu_a), .b(alu_b), .funct7(alu_f), .sel(alu_s), .y(alu_y));
  always_comb begin
    cmp_bit = op[0] ? (acc[31] ^ b_r[31] ? b_r[31] : alu_y[31]) : (acc[31] != b_r[31] ? acc[31] : alu_y[31]);
    shift_next = op[0] ? {sra_r & acc[31], acc[31:1]} : {acc[30:0], 1'b0};
  end
`ifdef ALU_SEQ_BARREL_EN
  logic [31:0] barrel;
  always_comb barrel = !sel[0] ? in1 << shamt : funct7 == 7'h20 ? 32'($signed(in1) >>> shamt) : in1 >> shamt;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc <= '0;
      b_r <= '0;
      out_r <= '0;
      cnt <= '0;
      op <= '0;
      sra_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= in1;
          b_r <= in2;
          op <= sel[1:0];
          sra_r <= funct7 == 7'h20;
          cnt <= shamt_ext;
          if (sel[3]) begin
            out_r <= '0;
            state <= DONE;
          end else if (!sel[2]) begin
            out_r <= alu_y;
            state <= DONE;
          end else if (sel[1]) begin
            state <= CALC;
`ifdef ALU_SEQ_BARREL_EN
          end else begin
            out_r <= barrel;
            state <= DONE;
`else
          end else if (shamt == '0) begin
            out_r <= in1;
            state <= DONE;
          end else begin
            state <= CALC;
`endif
          end
        end
        CALC: if (op[1]) begin
          out_r <= {31'b0, cmp_bit};
          state <= DONE;
        end else begin
          acc <= shift_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out_r <= shift_next;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out = out_r;
endmodule
